register_file_mp: RTL

//   Parametrised multi-read-port integer register file for the next (pipelined) core.

---
 rtl/rf_pkg.sv | 10 +
 rtl/rf_scoreboard.sv | 59 +++++
 rtl/register_file_mp.sv | 76 +++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared defaults and constants for the pipelined register file.
package rf_pkg;

   localparam int DEF_DATA_WIDTH   = 32;
   localparam int DEF_NUM_REGISTER = 32;

   // Register x0 is hard-wired to zero and never becomes pending.
   localparam int X0_ADDR = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-producer scoreboard: one busy bit per register plus a running count
// of how many bits are set. Flush beats issue, and issue beats writeback.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter  int NUM_REGISTER = DEF_NUM_REGISTER,
   localparam int ADDR_W       = $clog2(NUM_REGISTER),
   localparam int CNT_W        = $clog2(NUM_REGISTER) + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    issue,
   input  logic [ADDR_W-1:0]       issue_addr,
   input  logic                    we,
   input  logic [ADDR_W-1:0]       rd_addr,
   input  logic                    flush,
   output logic [NUM_REGISTER-1:0] busy,
   output logic [CNT_W-1:0]        pending_cnt
);

   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(X0_ADDR);

   logic                    issue_hit;
   logic                    wb_hit;
   logic                    inc;
   logic                    dec;
   logic [NUM_REGISTER-1:0] busy_next;

   // Next busy vector and counter deltas; a same-cycle issue keeps its bit set.
   always_comb begin
      issue_hit = issue && (issue_addr != ZERO_ADDR);
      wb_hit    = we && (rd_addr != ZERO_ADDR);
      inc       = issue_hit && !busy[issue_addr];
      dec       = wb_hit && busy[rd_addr] && !(issue_hit && (issue_addr == rd_addr));
      busy_next = busy;
      if (dec) begin
         busy_next[rd_addr] = 1'b0;
      end
      if (issue_hit) begin
         busy_next[issue_addr] = 1'b1;
      end
      busy_next[0] = 1'b0;
   end

   // Busy bits and counter update together so the count always matches the bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy        <= '0;
         pending_cnt <= '0;
      end else if (flush) begin
         busy        <= '0;
         pending_cnt <= '0;
      end else begin
         busy        <= busy_next;
         pending_cnt <= pending_cnt + CNT_W'(inc) - CNT_W'(dec);
      end
   end

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file with write-first bypass, RAW stall detection
// and a pending-producer scoreboard with flush.
module register_file_mp
   import rf_pkg::*;
#(
   parameter  int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter  int NUM_REGISTER = DEF_NUM_REGISTER,
   parameter  int NUM_READ     = 2,
   parameter  int RESET_INDEX  = 0,
   localparam int ADDR_W       = $clog2(NUM_REGISTER),
   localparam int CNT_W        = $clog2(NUM_REGISTER) + 1
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_we,
   input  logic [ADDR_W-1:0]              i_rd_addr,
   input  logic [DATA_WIDTH-1:0]          i_rd,
   input  logic [NUM_READ*ADDR_W-1:0]     i_rs_addr,
   input  logic [NUM_READ-1:0]            i_rs_valid,
   output logic [NUM_READ*DATA_WIDTH-1:0] o_rs,
   output logic [NUM_READ-1:0]            o_rs_busy,
   output logic                           o_stall,
   input  logic                           i_issue,
   input  logic [ADDR_W-1:0]              i_issue_addr,
   input  logic                           i_flush,
   output logic [CNT_W-1:0]               o_pending_cnt
);

   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(X0_ADDR);

   logic [DATA_WIDTH-1:0]   mem [NUM_REGISTER];
   logic [NUM_REGISTER-1:0] busy;

   // Data array: reset to zero or to the register index; writes to x0 are dropped.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < NUM_REGISTER; i++) begin
            mem[i] <= (RESET_INDEX != 0) ? DATA_WIDTH'(i) : '0;
         end
      end else if (i_we && (i_rd_addr != ZERO_ADDR)) begin
         mem[i_rd_addr] <= i_rd;
      end
   end

   // Each read port is a pure mux: x0, then the in-flight writeback, then the array.
   // A matching writeback also resolves that port's hazard in the same cycle.
   for (genvar k = 0; k < NUM_READ; k++) begin : g_read
      logic [ADDR_W-1:0] addr;
      logic              bypass;

      assign addr   = i_rs_addr[k*ADDR_W +: ADDR_W];
      assign bypass = i_we && (i_rd_addr == addr);

      assign o_rs[k*DATA_WIDTH +: DATA_WIDTH] = (addr == ZERO_ADDR) ? '0 :
                                                bypass              ? i_rd :
                                                                      mem[addr];
      assign o_rs_busy[k] = busy[addr] & ~bypass;
   end

   assign o_stall = |(i_rs_valid & o_rs_busy);

   rf_scoreboard #(
      .NUM_REGISTER (NUM_REGISTER)
   ) u_scoreboard (
      .clk         (i_clk),
      .rst         (i_rst),
      .issue       (i_issue),
      .issue_addr  (i_issue_addr),
      .we          (i_we),
      .rd_addr     (i_rd_addr),
      .flush       (i_flush),
      .busy        (busy),
      .pending_cnt (o_pending_cnt)
   );

endmodule
